// File: rtl/req_encoder_seq.sv
// Sequential multi-hot to binary-index encoder: accepts a request vector, then emits one index per output beat.
// Build option: REQ_ENC_MSB_FIRST_EN selects MSB-first priority (default LSB-first).
module req_encoder_seq #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] pending;
    logic [N-1:0] pending_next;
    logic [N-1:0] sel_mask;

    // State and pending vector registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
        end
    end

    // Priority pick: the last assignment in scan order wins
    always_comb begin
        out_idx = '0;
`ifdef REQ_ENC_MSB_FIRST_EN
        for (int i = 0; i < int'(N); i++) begin
            if (pending[i]) out_idx = W'(i);
        end
`else
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (pending[i]) out_idx = W'(i);
        end
`endif
    end

    // Exactly one bit left means the current beat closes the vector
    assign out_last = (pending != '0) && ((pending & (pending - N'(1))) == '0);
    assign sel_mask = N'(1) << out_idx;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == BUSY);

    // Next-state logic; an all-zero request is accepted and dropped
    always_comb begin
        state_next   = state;
        pending_next = pending;
        case (state)
            IDLE: begin
                if (in_valid && (in_req != '0)) begin
                    pending_next = in_req;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    pending_next = pending & ~sel_mask;
                    if (out_last) state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

endmodule
